// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with input synchroniser, false-start rejection and error flags.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN (adds break_det and a BRK state).

module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int OVS       = 16,
  parameter int BAUD_DIV  = 326
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic                 tick,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                 break_det
`endif
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int SW = $clog2(OVS);
  localparam int BW = 4;

  localparam logic [CW-1:0] BAUD_LAST   = CW'(BAUD_DIV - 1);
  localparam logic [SW-1:0] S_MID       = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_LAST      = SW'(OVS - 1);
  localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    BRK
`endif
  } state_t;

  logic [CW-1:0]        baud_cnt;
  logic [1:0]           sync_q;
  logic                 rxs;

  state_t               state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        b_cnt_q, b_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 p_bad_q, p_bad_d;
  logic                 f_bad_q, f_bad_d;
  logic                 frame_done;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 par_bit_q, par_bit_d;
  logic                 break_done;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign tick = (baud_cnt == BAUD_LAST);

  // Synchroniser resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rxs = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      b_cnt_q   <= '0;
      shift_q   <= '0;
      p_bad_q   <= 1'b0;
      f_bad_q   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      b_cnt_q   <= b_cnt_d;
      shift_q   <= shift_d;
      p_bad_q   <= p_bad_d;
      f_bad_q   <= f_bad_d;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit_q <= par_bit_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    b_cnt_d    = b_cnt_q;
    shift_d    = shift_q;
    p_bad_d    = p_bad_q;
    f_bad_d    = f_bad_q;
    frame_done = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    par_bit_d  = par_bit_q;
    break_done = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        s_cnt_d = '0;
        b_cnt_d = '0;
        p_bad_d = 1'b0;
        f_bad_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_d = 1'b0;
`endif
        if (!rxs) begin
          state_d = START;
        end
      end

      // Start bit is re-checked at mid-bit; a high line there was only a glitch.
      START: begin
        if (tick) begin
          if (s_cnt_q == S_MID) begin
            s_cnt_d = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            if (b_cnt_q == B_DATA_LAST) begin
              b_cnt_d = '0;
              state_d = (PARITY != 0) ? PAR : STOP;
            end else begin
              b_cnt_d = b_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      PAR: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            p_bad_d = ((^shift_q) ^ rxs) != (PARITY == 1);
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_d = rxs;
`endif
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      // Frame completes at mid-stop so a following start edge is never missed.
      STOP: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            f_bad_d = f_bad_q | ~rxs;
            if (b_cnt_q == B_STOP_LAST) begin
              b_cnt_d = '0;
`ifdef UART_RX_BREAK_DETECT_EN
              if (f_bad_d && (shift_q == '0) && !par_bit_q) begin
                break_done = 1'b1;
                state_d    = BRK;
              end else begin
                frame_done = 1'b1;
                state_d    = IDLE;
              end
`else
              frame_done = 1'b1;
              state_d    = IDLE;
`endif
            end else begin
              b_cnt_d = b_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_BREAK_DETECT_EN
      BRK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // rd_ack in the completion cycle consumes the old word, so the new one is not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done     <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_det   <= 1'b0;
`endif
    end else begin
      rx_done <= frame_done;
`ifdef UART_RX_BREAK_DETECT_EN
      break_det <= break_done;
`endif
      if (frame_done) begin
        data_out   <= shift_q;
        parity_err <= p_bad_q;
        frame_err  <= f_bad_d;
        data_valid <= 1'b1;
        if (data_valid && !rd_ack) begin
          overrun_err <= 1'b1;
        end
      end else if (rd_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and an even-parity instance, both with BAUD_DIV = 4.
// Break detection is exercised when UART_RX_BREAK_DETECT_EN is defined.

module tb_uart_rx_param;

  localparam int BT = 64;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       oerr;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       rxd_a, rxd_b;
  logic       rd_ack_a, rd_ack_b;
  logic       tick_a, tick_b;
  logic       rx_done_a, rx_done_b;
  logic [7:0] data_out_a, data_out_b;
  logic       data_valid_a, data_valid_b;
  logic       parity_err_a, parity_err_b;
  logic       frame_err_a, frame_err_b;
  logic       overrun_err_a, overrun_err_b;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       break_det_a, break_det_b;
  int         brk_count;
`endif

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   checks;
  int   errors;

  uart_rx_param #(
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVS(16), .BAUD_DIV(4)
  ) u_dut (
    .clk(clk), .reset(reset), .rxd(rxd_a), .rd_ack(rd_ack_a),
    .tick(tick_a), .rx_done(rx_done_a), .data_out(data_out_a),
    .data_valid(data_valid_a), .parity_err(parity_err_a),
    .frame_err(frame_err_a), .overrun_err(overrun_err_a)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(break_det_a)
`endif
  );

  uart_rx_param #(
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVS(16), .BAUD_DIV(4)
  ) u_par (
    .clk(clk), .reset(reset), .rxd(rxd_b), .rd_ack(rd_ack_b),
    .tick(tick_b), .rx_done(rx_done_b), .data_out(data_out_b),
    .data_valid(data_valid_b), .parity_err(parity_err_b),
    .frame_err(frame_err_b), .overrun_err(overrun_err_b)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(break_det_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input bit sel, input logic [7:0] d, input logic p, input logic f, input logic o);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.ferr = f;
    e.oerr = o;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int cycles);
    if (sel) rxd_b = v;
    else     rxd_a = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Sends one frame; a bad stop bit is held low only long enough to cover the mid-bit sample.
  task automatic apply_stimulus(input bit sel, input logic [7:0] d, input bit has_par,
                                input logic pbit, input logic stop_ok, input int idle);
    drive_bit(sel, 1'b0, BT);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], BT);
    if (has_par) drive_bit(sel, pbit, BT);
    if (stop_ok) begin
      drive_bit(sel, 1'b1, BT);
    end else begin
      drive_bit(sel, 1'b0, 48);
      drive_bit(sel, 1'b1, BT - 48);
    end
    drive_bit(sel, 1'b1, idle);
  endtask

  task automatic pulse_ack(input bit sel);
    @(negedge clk);
    if (sel) rd_ack_b = 1'b1;
    else     rd_ack_a = 1'b1;
    @(negedge clk);
    rd_ack_a = 1'b0;
    rd_ack_b = 1'b0;
  endtask

  function automatic int qsize(input bit sel);
    return sel ? q_b.size() : q_a.size();
  endfunction

  task automatic drain(input bit sel);
    int n;
    n = 0;
    while (qsize(sel) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output(sel ? "frame_missing_b" : "frame_missing_a", qsize(sel), 0);
    if (sel) q_b.delete();
    else     q_a.delete();
  endtask

  always @(negedge clk) begin
    if (!reset && rx_done_a) begin
      if (q_a.size() == 0) begin
        check_output("rx_done_a_unexpected", {31'b0, rx_done_a}, 0);
      end else begin
        ea = q_a.pop_front();
        check_output("data_out_a", {24'b0, data_out_a}, {24'b0, ea.data});
        check_output("parity_err_a", {31'b0, parity_err_a}, {31'b0, ea.perr});
        check_output("frame_err_a", {31'b0, frame_err_a}, {31'b0, ea.ferr});
        check_output("overrun_err_a", {31'b0, overrun_err_a}, {31'b0, ea.oerr});
        check_output("data_valid_a", {31'b0, data_valid_a}, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && rx_done_b) begin
      if (q_b.size() == 0) begin
        check_output("rx_done_b_unexpected", {31'b0, rx_done_b}, 0);
      end else begin
        eb = q_b.pop_front();
        check_output("data_out_b", {24'b0, data_out_b}, {24'b0, eb.data});
        check_output("parity_err_b", {31'b0, parity_err_b}, {31'b0, eb.perr});
        check_output("frame_err_b", {31'b0, frame_err_b}, {31'b0, eb.ferr});
        check_output("overrun_err_b", {31'b0, overrun_err_b}, {31'b0, eb.oerr});
        check_output("data_valid_b", {31'b0, data_valid_b}, 1);
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  initial brk_count = 0;
  always @(negedge clk) begin
    if (!reset && break_det_a) brk_count++;
  end
`endif

  initial begin
    int n;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    rxd_a    = 1'b1;
    rxd_b    = 1'b1;
    rd_ack_a = 1'b0;
    rd_ack_b = 1'b0;
    repeat (3) @(negedge clk);

    check_output("reset_tick", {31'b0, tick_a}, 0);
    check_output("reset_rx_done", {31'b0, rx_done_a}, 0);
    check_output("reset_data_out", {24'b0, data_out_a}, 0);
    check_output("reset_data_valid", {31'b0, data_valid_a}, 0);
    check_output("reset_parity_err", {31'b0, parity_err_a}, 0);
    check_output("reset_frame_err", {31'b0, frame_err_a}, 0);
    check_output("reset_overrun_err", {31'b0, overrun_err_a}, 0);
    check_output("reset_data_valid_b", {31'b0, data_valid_b}, 0);
    reset = 1'b0;

    n = 0;
    repeat (400) begin
      @(negedge clk);
      if (tick_a) n++;
    end
    check_output("tick_count", n, 100);

    // Basic 8N1 frame
    expect_frame(0, 8'hA5, 0, 0, 0);
    apply_stimulus(0, 8'hA5, 0, 1'b0, 1'b1, 2 * BT);
    drain(0);
    check_output("held_valid_a5", {31'b0, data_valid_a}, 1);
    pulse_ack(0);
    check_output("ack_clears_valid", {31'b0, data_valid_a}, 0);

    // Glitch shorter than half a bit
    drive_bit(0, 1'b0, 12);
    drive_bit(0, 1'b1, 4 * BT);
    check_output("glitch_valid", {31'b0, data_valid_a}, 0);

    // Framing error then recovery
    expect_frame(0, 8'h3C, 0, 1, 0);
    apply_stimulus(0, 8'h3C, 0, 1'b0, 1'b0, 2 * BT);
    drain(0);
    pulse_ack(0);
    expect_frame(0, 8'h3C, 0, 0, 0);
    apply_stimulus(0, 8'h3C, 0, 1'b0, 1'b1, 2 * BT);
    drain(0);
    pulse_ack(0);

    // Consumer acks between frames: no overrun
    expect_frame(0, 8'h11, 0, 0, 0);
    apply_stimulus(0, 8'h11, 0, 1'b0, 1'b1, 0);
    pulse_ack(0);
    expect_frame(0, 8'h22, 0, 0, 0);
    apply_stimulus(0, 8'h22, 0, 1'b0, 1'b1, BT);
    drain(0);
    check_output("no_overrun", {31'b0, overrun_err_a}, 0);
    pulse_ack(0);

    // Back-to-back without ack: overrun, newest data kept
    expect_frame(0, 8'h11, 0, 0, 0);
    expect_frame(0, 8'h22, 0, 0, 1);
    apply_stimulus(0, 8'h11, 0, 1'b0, 1'b1, 0);
    apply_stimulus(0, 8'h22, 0, 1'b0, 1'b1, BT);
    drain(0);
    check_output("overrun_sticky", {31'b0, overrun_err_a}, 1);
    check_output("overrun_data", {24'b0, data_out_a}, 32'h22);

    // Reset during the data bits of 0x77
    drive_bit(0, 1'b0, BT);
    drive_bit(0, 1'b1, 3 * BT);
    #3 reset = 1'b1;
    #1;
    check_output("midreset_data_valid", {31'b0, data_valid_a}, 0);
    check_output("midreset_overrun", {31'b0, overrun_err_a}, 0);
    check_output("midreset_data_out", {24'b0, data_out_a}, 0);
    check_output("midreset_rx_done", {31'b0, rx_done_a}, 0);
    rxd_a = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    drive_bit(0, 1'b1, 2 * BT);
    check_output("after_reset_valid", {31'b0, data_valid_a}, 0);

    expect_frame(0, 8'h81, 0, 0, 0);
    apply_stimulus(0, 8'h81, 0, 1'b0, 1'b1, 2 * BT);
    drain(0);
    pulse_ack(0);

`ifdef UART_RX_BREAK_DETECT_EN
    drive_bit(0, 1'b0, 12 * BT);
    drive_bit(0, 1'b1, 2 * BT);
    check_output("break_pulses", brk_count, 1);
    check_output("break_valid", {31'b0, data_valid_a}, 0);
    check_output("break_data_out", {24'b0, data_out_a}, 32'h81);
`else
    // Line low through a whole frame: all-zero frame with a framing error
    expect_frame(0, 8'h00, 0, 1, 0);
    drive_bit(0, 1'b0, 9 * BT + 48);
    drive_bit(0, 1'b1, 2 * BT);
    drain(0);
    pulse_ack(0);
`endif

    expect_frame(0, 8'h55, 0, 0, 0);
    apply_stimulus(0, 8'h55, 0, 1'b0, 1'b1, 2 * BT);
    drain(0);

    // Even parity instance
    expect_frame(1, 8'h0F, 1, 0, 0);
    apply_stimulus(1, 8'h0F, 1, 1'b1, 1'b1, BT);
    drain(1);
    pulse_ack(1);
    expect_frame(1, 8'h0F, 0, 0, 0);
    apply_stimulus(1, 8'h0F, 1, 1'b0, 1'b1, BT);
    drain(1);
    pulse_ack(1);
    expect_frame(1, 8'h07, 0, 0, 0);
    apply_stimulus(1, 8'h07, 1, 1'b1, 1'b1, BT);
    drain(1);
    pulse_ack(1);
    expect_frame(1, 8'h07, 1, 0, 0);
    apply_stimulus(1, 8'h07, 1, 1'b0, 1'b1, BT);
    drain(1);
    pulse_ack(1);
    check_output("parity_ack_valid", {31'b0, data_valid_b}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
